// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_pkg
//  Description : Shared types, defaults and checksum helper for the UART
//                command-frame parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    // Parser states; the frame layout is SYNC, CMD, LEN, PAYLOAD[LEN], CSUM.
    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4,
        DRAIN   = 3'd5
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running 8-bit two's-complement checksum step (wraps modulo 256).
    function automatic logic [7:0] csum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf
//  Description : Payload store for one frame. Synchronous write port,
//                asynchronous read port; the parent registers the read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Write one payload byte per accepted rx strobe.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Recovers SYNC/CMD/LEN/PAYLOAD/CSUM frames from a UART byte
//                strobe stream, buffers the payload and releases it as a
//                header pulse plus valid/ready byte stream once the checksum
//                verifies. Malformed, stalled or overrun frames raise
//                single-cycle error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         MAX_LEN      = 64,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = CLK_HZ / 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       hdr_valid,
    output logic [7:0] hdr_cmd,
    output logic [7:0] hdr_len,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    // Pointer and idle-counter widths; clamp to 1 so degenerate parameters
    // still give legal vectors.
    localparam int c_PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [7:0]        c_MAX_LEN = 8'(MAX_LEN);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    frame_state_t r_state;
    frame_state_t w_next;

    logic [7:0]         r_cmd;
    logic [7:0]         r_len;
    logic [7:0]         r_sum;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_TO_W-1:0]  r_idle;

    logic       r_hdr_valid;
    logic [7:0] r_hdr_cmd;
    logic [7:0] r_hdr_len;
    logic [7:0] r_m_data;
    logic       r_m_valid;
    logic       r_m_last;
    logic       r_err_csum;
    logic       r_err_len;
    logic       r_err_timeout;
    logic       r_err_overrun;
    logic       r_busy;

    logic       w_timed;
    logic       w_timeout;
    logic [7:0] w_sum_next;
    logic       w_csum_ok;
    logic       w_len_bad;
    logic       w_wr_last;
    logic       w_hs;
    logic       w_buf_we;
    logic [7:0] w_rd_data;

    // Idle supervision applies only while a frame is being received.
    assign w_timed    = (r_state == CMD) || (r_state == LEN) ||
                        (r_state == PAYLOAD) || (r_state == CSUM);
    // A byte arriving on the final idle cycle wins over the timeout.
    assign w_timeout  = w_timed && !rx_valid && (r_idle == c_TO_LAST);
    assign w_sum_next = csum8(r_sum, rx_data);
    assign w_csum_ok  = (w_sum_next == 8'd0);
    assign w_len_bad  = (rx_data > c_MAX_LEN);
    assign w_wr_last  = (8'(r_wr_ptr) == (r_len - 8'd1));
    assign w_hs       = r_m_valid && m_ready;
    assign w_buf_we   = (r_state == PAYLOAD) && rx_valid;

    frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (c_PTR_W)
    ) u_frame_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode driven by rx strobes, timeout and drain handshakes.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_next = CMD;
                end
            end
            CMD: begin
                if (rx_valid) begin
                    w_next = LEN;
                end else if (w_timeout) begin
                    w_next = HUNT;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (w_len_bad) begin
                        w_next = HUNT;
                    end else if (rx_data == 8'd0) begin
                        w_next = CSUM;
                    end else begin
                        w_next = PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_next = HUNT;
                end
            end
            PAYLOAD: begin
                if (rx_valid && w_wr_last) begin
                    w_next = CSUM;
                end else if (w_timeout) begin
                    w_next = HUNT;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    w_next = (w_csum_ok && (r_len != 8'd0)) ? DRAIN : HUNT;
                end else if (w_timeout) begin
                    w_next = HUNT;
                end
            end
            DRAIN: begin
                if (w_hs && r_m_last) begin
                    w_next = HUNT;
                end
            end
            default: begin
                w_next = HUNT;
            end
        endcase
    end

    // Frame datapath, idle counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd         <= 8'd0;
            r_len         <= 8'd0;
            r_sum         <= 8'd0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_idle        <= '0;
            r_hdr_valid   <= 1'b0;
            r_hdr_cmd     <= 8'd0;
            r_hdr_len     <= 8'd0;
            r_m_data      <= 8'd0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_hdr_valid   <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= w_timeout;
            r_err_overrun <= 1'b0;
            r_busy        <= (w_next != HUNT);

            // Counter restarts on every byte and on every state entry.
            if (!w_timed || rx_valid || (w_next != r_state)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_TO_ONE;
            end

            unique case (r_state)
                CMD: begin
                    if (rx_valid) begin
                        r_cmd <= rx_data;
                        r_sum <= rx_data;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        r_sum <= w_sum_next;
                        if (w_len_bad) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_len    <= rx_data;
                            r_wr_ptr <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        r_sum    <= w_sum_next;
                        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    end
                end
                CSUM: begin
                    if (rx_valid) begin
                        if (w_csum_ok) begin
                            r_hdr_valid <= 1'b1;
                            r_hdr_cmd   <= r_cmd;
                            r_hdr_len   <= r_len;
                            if (r_len != 8'd0) begin
                                // Read pointer is 0 here, so the first byte
                                // goes out alongside the header pulse.
                                r_m_valid <= 1'b1;
                                r_m_data  <= w_rd_data;
                                r_m_last  <= (r_len == 8'd1);
                                r_rd_ptr  <= c_PTR_ONE;
                            end
                        end else begin
                            r_err_csum <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Single buffer: anything arriving now is lost.
                    if (rx_valid) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_m_last) begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_rd_ptr  <= '0;
                        end else begin
                            // r_rd_ptr already addresses the next byte.
                            r_m_data <= w_rd_data;
                            r_m_last <= (8'(r_rd_ptr) == (r_len - 8'd1));
                            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hdr_valid   = r_hdr_valid;
    assign hdr_cmd     = r_hdr_cmd;
    assign hdr_len     = r_hdr_len;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign err_csum    = r_err_csum;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_parser
//  Description : Self-checking bench for uart_frame_parser: directed frames
//                plus randomized frames scored against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int         c_MAX_LEN = 16;
    localparam int         c_CLK_HZ  = 20_000;
    localparam int         c_TO      = c_CLK_HZ / 100;
    localparam logic [7:0] c_SYNC    = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       hdr_valid;
    logic [7:0] hdr_cmd;
    logic [7:0] hdr_len;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       err_csum;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    uart_frame_parser #(
        .CLK_HZ       (c_CLK_HZ),
        .MAX_LEN      (c_MAX_LEN),
        .SYNC_BYTE    (c_SYNC),
        .TIMEOUT_CLKS (c_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .hdr_valid   (hdr_valid),
        .hdr_cmd     (hdr_cmd),
        .hdr_len     (hdr_len),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .err_csum    (err_csum),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- observation (sampled on the falling edge) -------------
    logic [15:0] obs_hdr[$];
    logic [8:0]  obs_pay[$];
    int n_csum, n_len, n_to, n_ov, n_mv;
    int hdr_cyc, first_hs, last_hs, to_cyc;
    logic hdr_mvalid;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (hdr_valid) begin
                obs_hdr.push_back({hdr_cmd, hdr_len});
                hdr_cyc    = cyc;
                hdr_mvalid = m_valid;
            end
            if (m_valid) n_mv++;
            if (m_valid && m_ready) begin
                if (obs_pay.size() == 0) first_hs = cyc;
                last_hs = cyc;
                obs_pay.push_back({m_last, m_data});
            end
            if (err_csum) n_csum++;
            if (err_len) n_len++;
            if (err_overrun) n_ov++;
            if (err_timeout) begin
                n_to++;
                to_cyc = cyc;
            end
            if ((err_csum | err_len | err_timeout | err_overrun) == 1'b1)
                chk("err_onehot", $countones({err_csum, err_len, err_timeout, err_overrun}), 1);
            if (prev_stall)
                chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // ---------------- consumer ready generator ------------------------------
    int rdy_mode = 0;   // 0: always, 1: random, 2: stalled, 3: 1,0,0,1 pattern
    int rdy_idx  = 0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = 1'b0;
                default: begin
                    m_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
                    rdy_idx++;
                end
            endcase
        end
    end

    // ---------------- frame model and stimulus helpers ----------------------
    logic [7:0] fr[$];
    logic [7:0] exp_pay[$];
    int exp_hdr, exp_csum, exp_len, exp_to, exp_ov;
    logic [7:0] exp_cmd, exp_lenv;
    int last_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic load(input int n, input logic [63:0] v);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic build(input logic [7:0] cmd, input int len, input int corrupt);
        int s;
        logic [7:0] b;
        fr.delete();
        fr.push_back(c_SYNC);
        fr.push_back(cmd);
        fr.push_back(8'(len));
        if (len <= c_MAX_LEN) begin
            s = int'(cmd) + len;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                fr.push_back(b);
                s += int'(b);
            end
            fr.push_back(8'((256 - (s % 256) + corrupt) % 256));
        end
    endtask

    // Outcome of a frame from its byte list: length rule, then checksum rule.
    task automatic model();
        int s;
        int len;
        exp_pay.delete();
        exp_hdr = 0; exp_csum = 0; exp_len = 0; exp_to = 0; exp_ov = 0;
        if (fr.size() >= 3) begin
            len = int'(fr[2]);
            if (len > c_MAX_LEN) begin
                exp_len = 1;
            end else if (fr.size() == len + 4) begin
                s = 0;
                for (int i = 1; i < fr.size(); i++) s += int'(fr[i]);
                if ((s % 256) != 0) begin
                    exp_csum = 1;
                end else begin
                    exp_hdr  = 1;
                    exp_cmd  = fr[1];
                    exp_lenv = fr[2];
                    for (int i = 0; i < len; i++) exp_pay.push_back(fr[3+i]);
                end
            end
        end
    endtask

    task automatic begin_frame();
        obs_hdr.delete();
        obs_pay.delete();
        n_csum = 0; n_len = 0; n_to = 0; n_ov = 0; n_mv = 0;
        model();
    endtask

    task automatic play(input int n, input int maxgap, input int gpos, input int glen);
        for (int i = 0; i < n; i++) begin
            if (i == gpos) repeat (glen) step();
            else if (i > 0 && maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
            send_byte(fr[i]);
        end
    endtask

    task automatic finish_frame(input string nm);
        int n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        step();
        step();
        chk({nm, ":busy_idle"}, busy, 0);
        chk({nm, ":hdr_count"}, obs_hdr.size(), exp_hdr);
        if (exp_hdr == 1 && obs_hdr.size() > 0)
            chk({nm, ":hdr_fields"}, obs_hdr[0], {exp_cmd, exp_lenv});
        chk({nm, ":pay_count"}, obs_pay.size(), exp_pay.size());
        for (int i = 0; i < obs_pay.size() && i < exp_pay.size(); i++)
            chk({nm, ":pay_byte"}, obs_pay[i], {(i == exp_pay.size() - 1), exp_pay[i]});
        chk({nm, ":err_csum"}, n_csum, exp_csum);
        chk({nm, ":err_len"}, n_len, exp_len);
        chk({nm, ":err_timeout"}, n_to, exp_to);
        chk({nm, ":err_overrun"}, n_ov, exp_ov);
    endtask

    // ---------------- directed and randomized sequence ----------------------
    initial begin
        int kind;
        int len;
        int ng;
        logic [7:0] g;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {hdr_valid, hdr_cmd, hdr_len, m_data, m_valid, m_last,
                              err_csum, err_len, err_timeout, err_overrun, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // Good frame, continuous ready: one byte per cycle with the header.
        rdy_mode = 0;
        load(7, 64'h0000_00A5_1003_0102_03E7 >> 0);
        load(7, 64'h00A5_1003_0102_03E7);
        begin_frame();
        play(7, 0, -1, 0);
        finish_frame("good");
        chk("good:hdr_latency", hdr_cyc - last_cyc, 0);
        chk("good:hdr_with_mvalid", hdr_mvalid, 1);
        chk("good:first_hs", first_hs - hdr_cyc, 0);
        chk("good:burst", last_hs - first_hs, 2);

        // Zero-length frame.
        load(4, 64'h0000_0000_A520_00E0);
        begin_frame();
        play(4, 0, -1, 0);
        finish_frame("zero_len");
        chk("zero_len:m_valid_seen", n_mv, 0);

        // Bad checksum, then a good frame with leading garbage.
        load(7, 64'h00A5_1003_0102_03E8);
        begin_frame();
        play(7, 1, -1, 0);
        finish_frame("bad_csum");
        load(10, 64'h0000_0000_0000_0000);
        fr.delete();
        begin_frame();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        load(7, 64'h00A5_1003_0102_03E7);
        model();
        play(7, 0, -1, 0);
        finish_frame("garbage_then_good");

        // LEN just above the maximum.
        build(8'h44, c_MAX_LEN + 1, 0);
        begin_frame();
        play(fr.size(), 0, -1, 0);
        finish_frame("len_over");

        // LEN exactly at the maximum.
        build(8'h45, c_MAX_LEN, 0);
        begin_frame();
        play(fr.size(), 0, -1, 0);
        finish_frame("len_max");

        // Backpressure pattern 1,0,0,1.
        rdy_idx  = 0;
        rdy_mode = 3;
        build(8'h51, 5, 0);
        begin_frame();
        play(fr.size(), 0, -1, 0);
        finish_frame("backpressure");

        // Byte arriving while the payload is being drained.
        rdy_mode = 2;
        build(8'h52, 4, 0);
        begin_frame();
        exp_ov = 1;
        play(fr.size(), 0, -1, 0);
        repeat (3) step();
        send_byte(8'h5A);
        repeat (2) step();
        rdy_mode = 0;
        finish_frame("overrun");

        // Stop after SYNC, CMD: timeout after exactly TIMEOUT_CLKS cycles.
        load(2, 64'h0000_0000_0000_A510);
        begin_frame();
        exp_to = 1;
        play(2, 0, -1, 0);
        finish_frame("timeout");
        chk("timeout:latency", to_cyc - last_cyc, c_TO);

        // Inter-byte gap one short of the limit is still accepted.
        load(7, 64'h00A5_1003_0102_03E7);
        begin_frame();
        play(7, 0, 6, c_TO - 1);
        finish_frame("gap_limit_ok");

        // Gap equal to the limit times out; the late checksum is ignored.
        load(7, 64'h00A5_1003_0102_03E7);
        begin_frame();
        exp_pay.delete();
        exp_hdr = 0;
        exp_to  = 1;
        play(7, 0, 6, c_TO);
        finish_frame("gap_limit_to");

        // Asynchronous reset in the middle of a payload.
        build(8'h33, 8, 0);
        begin_frame();
        play(7, 0, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", {hdr_valid, hdr_cmd, hdr_len, m_data, m_valid, m_last,
                               err_csum, err_len, err_timeout, err_overrun, busy}, 32'd0);
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        step();
        build(8'h34, 6, 0);
        begin_frame();
        play(fr.size(), 1, -1, 0);
        finish_frame("after_reset");

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       rdy_mode = 0;
                1:       rdy_mode = 1;
                default: rdy_mode = 3;
            endcase
            if (kind == 0)      len = $urandom_range(c_MAX_LEN + 1, 255);
            else if (kind == 1) len = 0;
            else if (kind == 2) len = c_MAX_LEN;
            else                len = $urandom_range(1, c_MAX_LEN);
            build(8'($urandom), len, (kind == 3) ? $urandom_range(1, 255) : 0);
            begin_frame();
            ng = $urandom_range(0, 2);
            for (int k = 0; k < ng; k++) begin
                g = 8'($urandom);
                if (g == c_SYNC) g = 8'h00;
                send_byte(g);
            end
            play(fr.size(), 3, -1, 0);
            finish_frame("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART byte receiver. It consumes the receiver's 1-cycle byte strobes and recovers host command frames of the form SYNC, CMD, LEN, PAYLOAD[LEN], CSUM. Each frame is buffered whole and released to the accelerator control logic only after its checksum verifies. Release is a header pulse plus a valid/ready payload stream; malformed, stalled or overrun frames are reported on 1-cycle error pulses.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; used only to derive the timeout default.
MAX_LEN, 64, largest accepted payload length in bytes, range 1..255.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, CLK_HZ/100, maximum idle cycles between bytes inside a frame (10 ms).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  1-cycle strobe, rx_data valid
hdr_valid  out  1  1-cycle pulse: frame accepted
hdr_cmd  out  8  CMD of accepted frame; held until the next accepted frame
hdr_len  out  8  LEN of accepted frame; held until the next accepted frame
m_data  out  8  payload byte
m_valid  out  1  payload byte available
m_ready  in  1  consumer accepts m_data
m_last  out  1  m_data is the final payload byte
err_csum  out  1  1-cycle pulse: checksum mismatch
err_len  out  1  1-cycle pulse: LEN > MAX_LEN
err_timeout  out  1  1-cycle pulse: inter-byte timeout
err_overrun  out  1  1-cycle pulse: byte dropped while draining
busy  out  1  high in any state other than HUNT

Behaviour:
Reset and timing
- Reset is asynchronous. All outputs go to 0, state to HUNT, and all counters/pointers to 0.
- Reset may assert mid-frame or mid-drain; any partial frame is discarded with no error pulse.
- All outputs are registered.

State machine
- States: HUNT, CMD, LEN, PAYLOAD, CSUM, DRAIN.
- HUNT: on rx_valid with rx_data==SYNC_BYTE, go to CMD; all other bytes are ignored silently.
- CMD: on rx_valid, latch cmd, sum = rx_data, go to LEN.
- LEN:
  - on rx_valid with rx_data > MAX_LEN: pulse err_len next cycle, return to HUNT;
  - rx_data == 0: go to CSUM;
  - otherwise: latch len, wr_ptr = 0, go to PAYLOAD.
  - In all cases sum += rx_data.
- PAYLOAD: on rx_valid, write buf[wr_ptr], sum += rx_data, wr_ptr++. When wr_ptr == len-1 is written, go to CSUM.
- CSUM: on rx_valid, check (sum + rx_data) mod 256.
  - If nonzero: pulse err_csum, return to HUNT.
  - If zero: update hdr_cmd/hdr_len, pulse hdr_valid.
    - len == 0: return to HUNT.
    - len > 0: go to DRAIN; m_valid=1, m_data=buf[0], m_last=(len==1), all in the same cycle as hdr_valid.
- Checksum definition: 8-bit two's-complement. The sender picks CSUM so that CMD+LEN+payload+CSUM ≡ 0 mod 256.

Drain
- On m_valid && m_ready, rd_ptr++ and present the next byte the following cycle. This gives one byte per cycle under continuous m_ready.
- m_data, m_last are stable while m_valid && !m_ready.
- After the m_last handshake: m_valid=0, m_last=0, state HUNT on the next cycle.
- Any rx_valid seen in DRAIN, including in the cycle of the final handshake, is dropped and pulses err_overrun. The host protocol is request/ack, so no second buffer is provided.

Timeout
- Idle counter runs in CMD, LEN, PAYLOAD and CSUM. It clears on each rx_valid and on every state entry.
- When it reaches TIMEOUT_CLKS-1 with no rx_valid: pulse err_timeout, go to HUNT.
- An rx_valid in that same cycle wins: the byte is processed normally and no timeout occurs.

Widths
- Sum is 8-bit and wraps.
- wr_ptr/rd_ptr are $clog2(MAX_LEN) bits; the timeout counter is $clog2(TIMEOUT_CLKS) bits.
- Error pulses are mutually exclusive per cycle.

Decomposition:
- uart_frame_pkg holds:
  - typedef enum logic [2:0] frame_state_t {HUNT, CMD, LEN, PAYLOAD, CSUM, DRAIN};
  - localparam SYNC_BYTE_DEFAULT = 8'hA5;
  - function csum8(), for bench reuse.
- One sub-module: frame_buf, a MAX_LEN x 8 simple dual-port register array with a synchronous write port and an asynchronous read port indexed by rd_ptr. The parent registers its output into m_data.

Test Plan:
- Good frame: A5 10 03 01 02 03 E7 with m_ready=1 -> one hdr_valid (cmd=10, len=03); m_data 01,02,03 on consecutive cycles; m_last on 03; busy low afterwards.
- Zero-length frame: A5 20 00 E0 -> hdr_valid (cmd=20, len=0); m_valid never asserts; no errors.
- Bad checksum: A5 10 03 01 02 03 E8 -> err_csum pulse, no hdr_valid. A following good frame is accepted.
- Length/sync: LEN=MAX_LEN+1 -> err_len and return to HUNT; leading garbage 00 FF 5A before A5 is ignored with no error.
- Backpressure and overrun: good frame with m_ready toggling 1,0,0,1 -> m_data held while stalled. A byte sent during DRAIN -> err_overrun, payload intact.
- Timeout and reset: stop after A5 10 for TIMEOUT_CLKS cycles -> err_timeout, return to HUNT. Deassert rst_n mid-PAYLOAD -> all outputs 0 immediately, next frame parses normally.
